// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Desc   : Shared types and constants for the instruction-fetch stage.
// Rev    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam int NOP_INSTR = 0;
    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 12;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module : fetch_stage_if
// Desc   : Instruction-memory req/ack fetch bus.
// Rev    : 1.0  initial release
// ============================================================================
interface fetch_stage_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module : if_id_reg
// Desc   : IF/ID pipeline register; priority flush > stall > load.
// Rev    : 1.0  initial release
// ============================================================================
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               flush,
    input  wire logic               stall,
    input  wire logic               load,
    input  wire logic [INSTR_W-1:0] instr_in,
    input  wire logic [PC_W-1:0]    pc1_in,
    output logic      [INSTR_W-1:0] instr,
    output logic      [PC_W-1:0]    pc1,
    output logic                    valid
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc1_q,   pc1_d;
    logic               valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc1_d   = pc1_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = INSTR_W'(NOP_INSTR);
            pc1_d   = '0;
            valid_d = 1'b0;
        end else if (stall) begin
            instr_d = instr_q;
        end else if (load) begin
            instr_d = instr_in;
            pc1_d   = pc1_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= INSTR_W'(NOP_INSTR);
            pc1_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc1_q   <= pc1_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc1   = pc1_q;
    assign valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : fetch_stage
// Desc   : PC, fetch FSM (FETCH/HOLD/DRAIN) and IF/ID register.
//          Define FETCH_PERF_EN to add fetch/stall performance counters.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                stall,
    input  wire logic                if_id_flush,
    input  wire logic                branch_taken,
    input  wire logic [PC_W-1:0]     branch_target,
    input  wire logic                jump,
    input  wire logic [PC_W-1:0]     jump_target,
    fetch_stage_if.master            imem,
    output logic      [INSTR_W-1:0]  if_id_instr,
    output logic      [PC_W-1:0]     if_id_pc1,
    output logic                     if_id_valid
`ifdef FETCH_PERF_EN
    ,
    output logic      [31:0]         perf_fetch_cnt,
    output logic      [31:0]         perf_stall_cnt
`endif
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    drain_addr_q, drain_addr_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    logic [PC_W-1:0]    hold_pc1_q, hold_pc1_d;

    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic [PC_W-1:0]    pc_inc;
    logic               load_en;
    logic [INSTR_W-1:0] load_instr;
    logic [PC_W-1:0]    load_pc1;

    assign redirect    = branch_taken | jump;
    assign redirect_pc = branch_taken ? branch_target : jump_target;
    assign pc_inc      = pc_q + PC_W'(1);

    assign imem.imem_req  = !rst && (state_q != ST_HOLD);
    assign imem.imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        hold_instr_d = hold_instr_q;
        hold_pc1_d   = hold_pc1_q;
        load_en      = 1'b0;
        load_instr   = imem.imem_rdata;
        load_pc1     = pc_inc;
        unique case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (!imem.imem_ack) begin
                        state_d      = ST_DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (imem.imem_ack && !if_id_flush) begin
                    if (stall) begin
                        hold_instr_d = imem.imem_rdata;
                        hold_pc1_d   = pc_inc;
                        state_d      = ST_HOLD;
                    end else begin
                        load_en = 1'b1;
                        pc_d    = pc_inc;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = ST_FETCH;
                end else if (if_id_flush) begin
                    // Flushed word is dropped; pc is unchanged so it is refetched.
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    load_en    = 1'b1;
                    load_instr = hold_instr_q;
                    load_pc1   = hold_pc1_q;
                    pc_d       = pc_inc;
                    state_d    = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (redirect) pc_d = redirect_pc;
                // The ack retires the stale request; its data is never used.
                if (imem.imem_ack) state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            hold_instr_q <= '0;
            hold_pc1_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_pc1_q   <= hold_pc1_d;
        end
    end

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .flush    (if_id_flush),
        .stall    (stall),
        .load     (load_en),
        .instr_in (load_instr),
        .pc1_in   (load_pc1),
        .instr    (if_id_instr),
        .pc1      (if_id_pc1),
        .valid    (if_id_valid)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(load_en);
        stall_cnt_d = stall_cnt_q + 32'(stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_stage
// Desc   : Directed self-checking bench for fetch_stage.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, if_id_flush, branch_taken, jump;
    logic [15:0] branch_target, jump_target;
    logic [15:0] if_id_instr, if_id_pc1;
    logic        if_id_valid;
    logic        ack_en, ack_force;
    int          n_cmp = 0;
    int          n_err = 0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    fetch_stage_if #(.PC_W(16), .INSTR_W(16)) imem ();

    // Memory model: answers with 0x1000 + address.
    assign imem.imem_ack   = ack_force | (ack_en & imem.imem_req);
    assign imem.imem_rdata = 16'h1000 + imem.imem_addr;

    fetch_stage #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .if_id_flush   (if_id_flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem          (imem),
        .if_id_instr   (if_id_instr),
        .if_id_pc1     (if_id_pc1),
        .if_id_valid   (if_id_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall = 1'b0; if_id_flush = 1'b0;
        branch_taken = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0;
        ack_en = 1'b0; ack_force = 1'b0;
        #2;
        chk("req_in_reset", imem.imem_req, 0);
        tick();
        chk("rst_valid", if_id_valid, 0);
        chk("rst_instr", if_id_instr, 0);
        chk("rst_pc1", if_id_pc1, 0);
        rst = 1'b0;
        #1;
        chk("req_after_rst", imem.imem_req, 1);
        chk("addr_after_rst", imem.imem_addr, 16'h0000);

        // 1: back-to-back fetch
        ack_en = 1'b1;
        tick();
        chk("t1_instr0", if_id_instr, 16'h1000);
        chk("t1_pc1_0", if_id_pc1, 16'h0001);
        chk("t1_valid0", if_id_valid, 1);
        chk("t1_addr1", imem.imem_addr, 16'h0001);
        tick();
        chk("t1_instr1", if_id_instr, 16'h1001);
        chk("t1_pc1_1", if_id_pc1, 16'h0002);
        chk("t1_addr2", imem.imem_addr, 16'h0002);
        tick(); tick(); tick();
        chk("t1_addr5", imem.imem_addr, 16'h0005);
        chk("t1_instr4", if_id_instr, 16'h1004);

        // 2: stall while word 5 is acked
        stall = 1'b1;
        tick();
        chk("t2_hold_req", imem.imem_req, 0);
        chk("t2_hold_instr", if_id_instr, 16'h1004);
        chk("t2_hold_pc1", if_id_pc1, 16'h0005);
        tick();
        chk("t2_hold_req2", imem.imem_req, 0);
        chk("t2_hold_instr2", if_id_instr, 16'h1004);
        tick();
        chk("t2_hold_req3", imem.imem_req, 0);
        stall = 1'b0; ack_en = 1'b0;
        tick();
        chk("t2_rel_instr", if_id_instr, 16'h1005);
        chk("t2_rel_pc1", if_id_pc1, 16'h0006);
        chk("t2_rel_valid", if_id_valid, 1);
        chk("t2_rel_req", imem.imem_req, 1);
        chk("t2_rel_addr", imem.imem_addr, 16'h0006);

        // 3: branch + flush with no ack -> DRAIN
        branch_taken = 1'b1; branch_target = 16'h0040; if_id_flush = 1'b1;
        tick();
        branch_taken = 1'b0; if_id_flush = 1'b0;
        chk("t3_drain_addr", imem.imem_addr, 16'h0006);
        chk("t3_drain_req", imem.imem_req, 1);
        chk("t3_flush_instr", if_id_instr, 0);
        chk("t3_flush_valid", if_id_valid, 0);
        chk("t3_flush_pc1", if_id_pc1, 0);
        tick();
        chk("t3_drain_addr2", imem.imem_addr, 16'h0006);
        ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        chk("t3_new_addr", imem.imem_addr, 16'h0040);
        chk("t3_drop_valid", if_id_valid, 0);
        chk("t3_drop_instr", if_id_instr, 0);
        ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        chk("t3_tgt_instr", if_id_instr, 16'h1040);
        chk("t3_tgt_pc1", if_id_pc1, 16'h0041);
        chk("t3_tgt_valid", if_id_valid, 1);

        // 4: branch beats jump
        branch_taken = 1'b1; branch_target = 16'h0080;
        jump = 1'b1; jump_target = 16'h0090;
        tick();
        branch_taken = 1'b0; jump = 1'b0;
        chk("t4_drain_addr", imem.imem_addr, 16'h0041);
        chk("t4_keep_instr", if_id_instr, 16'h1040);
        ack_en = 1'b1;
        tick();
        chk("t4_new_addr", imem.imem_addr, 16'h0080);
        tick();
        ack_en = 1'b0;
        chk("t4_instr", if_id_instr, 16'h1080);
        chk("t4_pc1", if_id_pc1, 16'h0081);

        // 5: jump with same-cycle ack, then PC wrap
        jump = 1'b1; jump_target = 16'hFFFF; ack_en = 1'b1;
        tick();
        jump = 1'b0;
        chk("t5_addr_ffff", imem.imem_addr, 16'hFFFF);
        chk("t5_dropped", if_id_instr, 16'h1080);
        tick();
        ack_en = 1'b0;
        chk("t5_wrap_instr", if_id_instr, 16'h0FFF);
        chk("t5_wrap_pc1", if_id_pc1, 16'h0000);
        chk("t5_wrap_addr", imem.imem_addr, 16'h0000);

        // 6: reset from HOLD and from DRAIN, with a stray ack
        stall = 1'b1; ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        chk("t6_hold_req", imem.imem_req, 0);
        rst = 1'b1; ack_force = 1'b1;
        #1;
        chk("t6_req_in_rst", imem.imem_req, 0);
        tick();
        rst = 1'b0; stall = 1'b0; ack_force = 1'b0;
        #1;
        chk("t6a_valid", if_id_valid, 0);
        chk("t6a_instr", if_id_instr, 0);
        chk("t6a_req", imem.imem_req, 1);
        chk("t6a_addr", imem.imem_addr, 16'h0000);
        branch_taken = 1'b1; branch_target = 16'h0020;
        tick();
        branch_taken = 1'b0;
        chk("t6b_drain_addr", imem.imem_addr, 16'h0000);
        rst = 1'b1; ack_force = 1'b1;
        tick();
        rst = 1'b0; ack_force = 1'b0;
        #1;
        chk("t6b_addr", imem.imem_addr, 16'h0000);
        chk("t6b_valid", if_id_valid, 0);
        ack_en = 1'b1;
        tick();
        ack_en = 1'b0;
        chk("t6b_instr", if_id_instr, 16'h1000);
        chk("t6b_pc1", if_id_pc1, 16'h0001);
        chk("t6b_valid_load", if_id_valid, 1);
        chk("t6b_addr_next", imem.imem_addr, 16'h0001);
`ifdef FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, 32'd1);
        chk("perf_stall", perf_stall_cnt, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
